sum_accum: RTL

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/adder_pkg.sv | 13 +
 rtl/sum_accum.sv | 103 ++++++++++
 2 files changed

// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the adder-sum block accumulator.
package adder_pkg;

  localparam int SUM_W_DEF = 5;
  localparam int NSAMP_DEF = 4;

  // ACCUM: collecting samples of a block. HOLD: presenting a finished block.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sum_accum.sv
// Block accumulator: gathers NSAMP adder sums into total, carry count and
// maximum, then holds the result until downstream takes it.
module sum_accum
  import adder_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int NSAMP = NSAMP_DEF,
  parameter int ACC_W = SUM_W + $clog2(NSAMP)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SUM_W-1:0]         in_sum,
  input  logic                     in_co,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_total,
  output logic [$clog2(NSAMP):0]   out_co_cnt,
  output logic [SUM_W-1:0]         out_max
);

  localparam int CNT_W = $clog2(NSAMP);

  acc_state_t         state;
  acc_state_t         state_nxt;
  logic               accept;
  logic               clr;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   total;
  logic [CNT_W:0]     co_cnt;
  logic [SUM_W-1:0]   max_sum;

  // A flush wins over any handshake in the same cycle.
  assign accept = in_valid && in_ready && !flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, handshake outputs and accumulator clear request.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (cnt == CNT_W'(NSAMP - 1))) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
          clr       = 1'b1;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    if (flush) begin
      state_nxt = ACCUM;
      clr       = 1'b1;
    end
  end

  // Accumulators: cleared on release/flush, updated only on an accepted sample.
  // The counter wraps to 0 on the last accept, so a new block starts at sample 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      total   <= '0;
      co_cnt  <= '0;
      max_sum <= '0;
    end else if (clr) begin
      cnt     <= '0;
      total   <= '0;
      co_cnt  <= '0;
      max_sum <= '0;
    end else if (accept) begin
      cnt    <= cnt + CNT_W'(1);
      total  <= total + ACC_W'(in_sum);
      co_cnt <= co_cnt + {{CNT_W{1'b0}}, in_co};
      if (in_sum > max_sum) begin
        max_sum <= in_sum;
      end
    end
  end

  // Results are only visible while a finished block is held.
  assign out_total  = out_valid ? total   : '0;
  assign out_co_cnt = out_valid ? co_cnt  : '0;
  assign out_max    = out_valid ? max_sum : '0;

endmodule
